// File: rtl/sm_addsub_pipe_if.sv
// Handshake and data bundle for sm_addsub_pipe.
// The dispatcher drives the master side.
// The add/subtract unit implements the slave side.
interface sm_addsub_pipe_if #(
    parameter int unsigned MAG_W     = 4,
    parameter int unsigned OUT_MAG_W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   op_sub;
    logic [MAG_W:0]         x;
    logic [MAG_W:0]         y;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_MAG_W+3:0]   out;

    modport master (
        output in_valid, op_sub, x, y, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, op_sub, x, y, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/sm_addsub_pipe.sv
// Two-stage elastic sign-magnitude add/subtract unit.
// Stage 1 registers the effective signs, the zero-extended magnitudes and the
// compare result. Stage 2 forms the tagged result word {OPCODE, ovf, sign, mag}.
// Optional macro SM_ADDSUB_SAT_EN: on overflow, the magnitude clamps to all ones
// instead of wrapping.
module sm_addsub_pipe #(
    parameter int unsigned MAG_W     = 4,
    parameter int unsigned OUT_MAG_W = 8,
    parameter logic [1:0]  OPCODE    = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    sm_addsub_pipe_if.slave  bus
);
    localparam int unsigned EW = OUT_MAG_W + 1;

    logic                 r_s1_valid;
    logic                 r_sx;
    logic                 r_sy;
    logic                 r_same;
    logic                 r_x_ge;
    logic [EW-1:0]        r_xm;
    logic [EW-1:0]        r_ym;
    logic                 r_out_valid;
    logic [OUT_MAG_W+3:0] r_out;

    logic                 w_in_ready;
    logic                 w_in_fire;
    logic                 w_s2_load;
    logic [EW-1:0]        w_true_mag;
    logic                 w_ovf;
    logic                 w_sign;
    logic [OUT_MAG_W-1:0] w_mag;

    assign w_in_ready    = rst_n && !(r_s1_valid && r_out_valid && !bus.out_ready);
    assign w_in_fire     = bus.in_valid && w_in_ready;
    assign w_s2_load     = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;

    // Stage 1: capture the operands with the effective sign of y and the magnitude compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_sx       <= 1'b0;
            r_sy       <= 1'b0;
            r_same     <= 1'b0;
            r_x_ge     <= 1'b0;
            r_xm       <= '0;
            r_ym       <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_sx       <= bus.x[MAG_W];
                r_sy       <= bus.y[MAG_W] ^ bus.op_sub;
                r_same     <= (bus.x[MAG_W] == (bus.y[MAG_W] ^ bus.op_sub));
                r_x_ge     <= (bus.x[MAG_W-1:0] >= bus.y[MAG_W-1:0]);
                r_xm       <= EW'(bus.x[MAG_W-1:0]);
                r_ym       <= EW'(bus.y[MAG_W-1:0]);
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 datapath: add or subtract the magnitudes, then flag overflow and normalise zero.
    // The zero test uses the untruncated magnitude, so a wrapped overflow keeps its sign.
    always_comb begin
        w_true_mag = '0;
        w_sign     = 1'b0;
        if (r_same) begin
            w_true_mag = r_xm + r_ym;
            w_sign     = r_sx;
        end else if (r_x_ge) begin
            w_true_mag = r_xm - r_ym;
            w_sign     = r_sx;
        end else begin
            w_true_mag = r_ym - r_xm;
            w_sign     = r_sy;
        end
        if (w_true_mag == '0) begin
            w_sign = 1'b0;
        end
        w_ovf = r_same && w_true_mag[OUT_MAG_W];
`ifdef SM_ADDSUB_SAT_EN
        w_mag = w_ovf ? '1 : w_true_mag[OUT_MAG_W-1:0];
`else
        w_mag = w_true_mag[OUT_MAG_W-1:0];
`endif
    end

    // Output register: load when it is empty or being drained, otherwise hold it stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= {OPCODE, w_ovf, w_sign, w_mag};
            end
        end
    end
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe.
// u_dut uses the default widths (out is 12 bits).
// u_dut4 uses OUT_MAG_W = 4 (out is 8 bits) and covers the overflow path.
// Both instances receive the same stimulus.
module tb_sm_addsub_pipe;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       op_sub;
    logic [4:0] x;
    logic [4:0] y;
    logic       out_ready;

    int unsigned n_pass;
    int unsigned n_total;

    sm_addsub_pipe_if #(.MAG_W(4), .OUT_MAG_W(8)) u_if ();
    sm_addsub_pipe_if #(.MAG_W(4), .OUT_MAG_W(4)) u_if4 ();

    assign u_if.in_valid   = in_valid;
    assign u_if.op_sub     = op_sub;
    assign u_if.x          = x;
    assign u_if.y          = y;
    assign u_if.out_ready  = out_ready;
    assign u_if4.in_valid  = in_valid;
    assign u_if4.op_sub    = op_sub;
    assign u_if4.x         = x;
    assign u_if4.y         = y;
    assign u_if4.out_ready = out_ready;

    sm_addsub_pipe #(.MAG_W(4), .OUT_MAG_W(8), .OPCODE(2'b01)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    sm_addsub_pipe #(.MAG_W(4), .OUT_MAG_W(4), .OPCODE(2'b01)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One isolated op with out_ready high: accepted, invisible a cycle later, then on out.
    task automatic op1(input string tag, input logic s, input logic [4:0] a, input logic [4:0] b,
                       input logic [11:0] exp);
        @(negedge clk);
        op_sub = s; x = a; y = b; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 16'(u_if.in_ready), 16'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat_valid"}, 16'(u_if.out_valid), 16'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 16'(u_if.out_valid), 16'd1);
        chk({tag, "_out"}, 16'(u_if.out), 16'(exp));
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; x = '0; y = '0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 16'(u_if.out_valid), 16'd0);
        chk("rst_out", 16'(u_if.out), 16'd0);
        chk("rst_in_ready", 16'(u_if.in_ready), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        op1("add_p5_p3", 1'b0, 5'b00101, 5'b00011, 12'h408);
        op1("add_p3_m5", 1'b0, 5'b00011, 5'b10101, 12'h502);
        op1("sub_p3_m5", 1'b1, 5'b00011, 5'b10101, 12'h408);
        op1("add_m2_p9", 1'b0, 5'b10010, 5'b01001, 12'h407);
        op1("cancel_p7_m7", 1'b0, 5'b00111, 5'b10111, 12'h400);
        op1("cancel_m4_sub_m4", 1'b1, 5'b10100, 5'b10100, 12'h400);
        op1("cancel_m0_p0", 1'b0, 5'b10000, 5'b00000, 12'h400);
        op1("add_p15_p15", 1'b0, 5'b01111, 5'b01111, 12'h41E);
`ifdef SM_ADDSUB_SAT_EN
        chk("ovf4_sat", 16'(u_if4.out), 16'h006F);
`else
        chk("ovf4_wrap", 16'(u_if4.out), 16'h006E);
`endif

        // Backpressure: four ops stream in while the consumer stalls.
        @(negedge clk);
        out_ready = 1'b0;
        op_sub = 1'b0; x = 5'd1; y = 5'd1; in_valid = 1'b1;
        chk("bp_rdy_a", 16'(u_if.in_ready), 16'd1);
        @(negedge clk);
        chk("bp_rdy_b", 16'(u_if.in_ready), 16'd1);
        x = 5'd2; y = 5'd2;
        @(negedge clk);
        chk("bp_out_a", 16'(u_if.out), 16'h402);
        chk("bp_rdy_full", 16'(u_if.in_ready), 16'd0);
        x = 5'd3; y = 5'd3;
        @(negedge clk);
        @(negedge clk);
        chk("bp_hold_valid", 16'(u_if.out_valid), 16'd1);
        chk("bp_hold_out", 16'(u_if.out), 16'h402);
        chk("bp_hold_rdy", 16'(u_if.in_ready), 16'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", 16'(u_if.in_ready), 16'd1);
        @(negedge clk);
        chk("bp_out_b", 16'(u_if.out), 16'h404);
        x = 5'd4; y = 5'd4;
        @(negedge clk);
        chk("bp_out_c", 16'(u_if.out), 16'h406);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out_d", 16'(u_if.out), 16'h408);
        chk("bp_valid_d", 16'(u_if.out_valid), 16'd1);
        @(negedge clk);
        chk("bp_drained", 16'(u_if.out_valid), 16'd0);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        x = 5'd6; y = 5'd1; in_valid = 1'b1;
        @(negedge clk);
        x = 5'd5; y = 5'd5;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_full_rdy", 16'(u_if.in_ready), 16'd0);
        chk("mid_full_out", 16'(u_if.out), 16'h407);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(u_if.out_valid), 16'd0);
        chk("mid_rst_out", 16'(u_if.out), 16'd0);
        chk("mid_rst_rdy", 16'(u_if.in_ready), 16'd0);
        chk("mid_rst_out4", 16'(u_if4.out), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_no_stale", 16'(u_if.out_valid), 16'd0);
        op1("post_rst_m4_sub_p4", 1'b1, 5'b10100, 5'b00100, 12'h508);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sm_addsub_pipe.md
Name: sm_addsub_pipe

Overview:
- Parametrised, pipelined sign-magnitude add/subtract unit for the ALU datapath.
- Operands are sign-magnitude: the MSB is the sign and the remaining bits are the magnitude.
- Produces a tagged result word: opcode tag, overflow flag, sign, and magnitude.
- Two-stage elastic pipeline with valid/ready handshakes on both sides. Sits between the operand dispatcher and the ALU result mux.

Parameters:
- MAG_W, 4, operand magnitude width; operands are MAG_W+1 bits.
- OUT_MAG_W, 8, result magnitude width; must be >= MAG_W.
- OPCODE, 2'b01, 2-bit tag placed in the top two result bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  unit can accept an operand pair.
- op_sub  in  1  0: x+y, 1: x-y.
- x  in  MAG_W+1  operand x: x[MAG_W] is the sign (1 = negative), x[MAG_W-1:0] is the magnitude.
- y  in  MAG_W+1  operand y, same format as x.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  OUT_MAG_W+4  result word:
  - [OUT_MAG_W+3:OUT_MAG_W+2] = OPCODE
  - [OUT_MAG_W+1] = ovf
  - [OUT_MAG_W] = sign
  - [OUT_MAG_W-1:0] = magnitude

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - s1_valid, out_valid and the out register all clear to 0 (out = 0, including the tag bits).
  - in_ready = 0 while rst_n is low.
  - Any operation in flight is discarded; no partial result is ever presented.
- Handshake:
  - An input transfer occurs on a clk edge where in_valid && in_ready.
  - An output transfer occurs on a clk edge where out_valid && out_ready.
  - in_ready = rst_n && !(s1_valid && out_valid && !out_ready). This is combinational, with no dependency on in_valid.
  - While out_valid && !out_ready, out holds stable.
  - Throughput is one operation per cycle when out_ready = 1.
- Latency: an accepted operand appears on out two cycles after acceptance when out_ready is held high.
- Stage 1 (registered):
  - sx = x sign; sy = y sign XOR op_sub (effective sign).
  - Register both magnitudes, zero-extended to OUT_MAG_W+1.
  - Register same = (sx == sy) and x_ge = (|x| >= |y|).
  - Stage 1 advances when stage 2 is empty or is draining in that same cycle.
- Stage 2 (registered to out):
  - If same: mag = |x| + |y|, sign = sx.
  - Else if x_ge: mag = |x| - |y|, sign = sx.
  - Else: mag = |y| - |x|, sign = sy.
  - Zero normalisation: if mag == 0, sign = 0. This covers -0 operands and equal-magnitude cancellation.
  - ovf = 1 when the true magnitude exceeds 2^OUT_MAG_W - 1. This is only possible on the same-sign path.
  - Without saturation (see Optional Feature), mag is truncated to its low OUT_MAG_W bits.
  - ovf = 0 whenever OUT_MAG_W > MAG_W.
- Simultaneous events: an input accept and an output drain in the same cycle are both honoured; the pipeline shifts with no bubble.
- Boundaries:
  - Operands -0 and +0 are treated as equal.
  - |x| == |y| with opposite effective signs gives out magnitude 0 and sign 0.

Optional Feature:
- Macro: SM_ADDSUB_SAT_EN.
- Defined: on overflow the magnitude clamps to all ones (2^OUT_MAG_W - 1), ovf = 1, and sign is kept.
- Not defined: the magnitude wraps (truncated), ovf = 1, and sign is kept.
- No port or latency change either way.

Test Plan:
- Defaults, out_ready = 1, op_sub = 0, x = 5'b00101 (+5), y = 5'b00011 (+3) -> after 2 cycles out_valid = 1, out = 12'h408.
- op_sub = 0, x = +3 (5'b00011), y = -5 (5'b10101) -> out = 12'h502 (sign 1, magnitude 2).
- Cancellation cases, each -> out = 12'h400 (sign normalised to 0):
  - x = +7, y = -7, add.
  - x = -4, y = -4, op_sub = 1.
  - x = 5'b10000 (-0), y = 5'b00000 (+0).
- OUT_MAG_W = 4, x = +15, y = +15, add:
  - SM_ADDSUB_SAT_EN undefined -> out = 8'h6E (ovf = 1, magnitude 14).
  - SM_ADDSUB_SAT_EN defined -> out = 8'h6F.
- Backpressure:
  - Stream 4 ops with out_ready = 0 -> in_ready drops after 2 accepts, out holds the first result stable.
  - Release out_ready -> results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst_n = 0 with both stages valid -> out_valid = 0, out = 0 and in_ready = 0 immediately. After release, first new op yields a correct result 2 cycles later with no stale output.
